spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave (modes 0-3) with a four-register processor port: control, status, tx_data, rx_data.
// rx_full is set 3 pro_clk edges after the raw sclk sample edge; miso moves 3 edges after a shift edge.
// No backpressure: an unread rx byte is overwritten and overrun is flagged; un-rewritten tx_data is resent.
module spi_slave (
    input  logic       pro_clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    inout  wire  [7:0] data_bus,
    input  logic       WR,
    input  logic       RD,
    input  logic [1:0] addr,
    input  logic       CS,
    output logic       irq
);

    localparam logic [1:0] ADDR_CTRL = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_TX   = 2'b10;
    localparam logic [1:0] ADDR_RX   = 2'b11;

    // Synchronizer stages plus one history flop each for edge detection.
    logic sclk_s1_q, sclk_s2_q, sclk_d1_q;
    logic ss_s1_q, ss_s2_q, ss_d1_q;
    logic mosi_s1_q, mosi_s2_q;

    // Architectural state.
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rx_full_q, rx_full_d;
    logic       tx_empty_q, tx_empty_d;
    logic       overrun_q, overrun_d;

    logic       cpol, cpha, active, ss_fall, sclk_chg;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       wr_en, rd_en, wr_ctrl, wr_tx, rd_rx, rd_stat;
    logic [7:0] rx_byte, tx_load_val, status, rd_dat;

    // Bring the master's asynchronous signals into the pro_clk domain.
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d1_q <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_d1_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d1_q <= sclk_s2_q;
            ss_s1_q   <= ss_n;
            ss_s2_q   <= ss_s1_q;
            ss_d1_q   <= ss_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign cpol     = ctrl_q[3];
    assign cpha     = ctrl_q[4];
    assign active   = ~ss_s2_q;
    assign ss_fall  = ss_d1_q & ~ss_s2_q;
    assign sclk_chg = sclk_s2_q ^ sclk_d1_q;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge   = active & sclk_chg & (sclk_s2_q != cpol);
    assign trail_edge  = active & sclk_chg & (sclk_s2_q == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;

    assign wr_en   = CS & WR;
    assign rd_en   = CS & RD;
    assign wr_ctrl = wr_en & (addr == ADDR_CTRL);
    assign wr_tx   = wr_en & (addr == ADDR_TX);
    assign rd_rx   = rd_en & (addr == ADDR_RX);
    assign rd_stat = rd_en & (addr == ADDR_STAT);

    // mosi and sclk share the same sync depth, so mosi_s2_q is aligned with the detected edge.
    assign rx_byte     = {rx_shift_q[6:0], mosi_s2_q};
    // A tx_data write landing on a load edge goes straight into the shifter.
    assign tx_load_val = wr_tx ? data_bus : tx_data_q;

    // Next-state logic: processor accesses first, then serial events which win on conflict.
    always_comb begin
        ctrl_d     = ctrl_q;
        tx_data_d  = tx_data_q;
        rx_data_d  = rx_data_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_full_d  = rx_full_q;
        tx_empty_d = tx_empty_q;
        overrun_d  = overrun_q;

        if (wr_ctrl) begin
            ctrl_d = data_bus;
        end
        if (wr_tx) begin
            tx_data_d  = data_bus;
            tx_empty_d = 1'b0;
        end
        if (rd_rx) begin
            rx_full_d = 1'b0;
        end
        if (rd_stat) begin
            overrun_d = 1'b0;
        end

        if (!active) begin
            // Deselected (or deselected mid-byte): drop any partial byte.
            bit_cnt_d = 3'd0;
        end else if (ss_fall) begin
            tx_shift_d = tx_load_val;
            tx_empty_d = 1'b1;
            rx_shift_d = 8'h00;
            bit_cnt_d  = 3'd0;
        end else if (sample_edge) begin
            if (bit_cnt_q == 3'd7) begin
                rx_data_d  = rx_byte;
                rx_full_d  = 1'b1;
                // A read of rx_data on this same edge has consumed the old byte.
                if (rx_full_q && !rd_rx) begin
                    overrun_d = 1'b1;
                end
                tx_shift_d = tx_load_val;
                tx_empty_d = 1'b1;
                rx_shift_d = 8'h00;
                bit_cnt_d  = 3'd0;
            end else begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
        end else if (shift_edge && (bit_cnt_q != 3'd0)) begin
            // The shift edge before the first sample of a byte (CPHA=1) or right after the
            // last one (CPHA=0) must leave the freshly loaded MSB on miso.
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
    end

    // Register update for all architectural state.
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rx_full_q  <= 1'b0;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tx_data_q  <= tx_data_d;
            rx_data_q  <= rx_data_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_full_q  <= rx_full_d;
            tx_empty_q <= tx_empty_d;
            overrun_q  <= overrun_d;
        end
    end

    assign status = {4'b0000, ~ss_s2_q, overrun_q, tx_empty_q, rx_full_q};

    // Processor read mux.
    always_comb begin
        rd_dat = 8'h00;
        case (addr)
            ADDR_CTRL: rd_dat = ctrl_q;
            ADDR_STAT: rd_dat = status;
            ADDR_TX:   rd_dat = tx_data_q;
            ADDR_RX:   rd_dat = rx_data_q;
            default:   rd_dat = 8'h00;
        endcase
    end

    assign data_bus = rd_en ? rd_dat : 8'bz;
    assign miso     = ss_s2_q ? 1'bz : tx_shift_q[7];
    assign irq      = rx_full_q & ctrl_q[0];

endmodule

// File: tb/tb_spi_slave.sv
// Randomized and directed bench for spi_slave driving an SPI master model and the processor port.
// Expected values come from a byte-level model of the register file and transfer rules.
// A pullup on miso makes the released (z) state observable as 1.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       pro_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sclk    = 1'b0;
    logic       mosi    = 1'b0;
    logic       ss_n    = 1'b1;
    logic       WR      = 1'b0;
    logic       RD      = 1'b0;
    logic       CS      = 1'b0;
    logic [1:0] addr    = 2'b00;
    logic       tb_drv  = 1'b0;
    logic [7:0] tb_dat  = 8'h00;
    wire        miso;
    wire  [7:0] data_bus;
    wire        irq;

    assign data_bus = tb_drv ? tb_dat : 8'bz;
    pullup (miso);

    spi_slave dut (
        .pro_clk  (pro_clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .miso     (miso),
        .data_bus (data_bus),
        .WR       (WR),
        .RD       (RD),
        .addr     (addr),
        .CS       (CS),
        .irq      (irq)
    );

    always #5 pro_clk = ~pro_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Byte-level reference model.
    logic [7:0] m_ctrl, m_tx, m_rxd, m_load;
    logic       m_rxf, m_txe, m_ovr, m_busy;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_busy, m_ovr, m_txe, m_rxf};
    endfunction

    task automatic m_reset();
        m_ctrl = 8'h00; m_tx = 8'h00; m_rxd = 8'h00; m_load = 8'h00;
        m_rxf = 1'b0; m_txe = 1'b1; m_ovr = 1'b0; m_busy = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge pro_clk);
        CS = 1'b1; WR = 1'b1; addr = a; tb_dat = d; tb_drv = 1'b1;
        @(negedge pro_clk);
        CS = 1'b0; WR = 1'b0; tb_drv = 1'b0;
        if (a == 2'b00) m_ctrl = d;
        if (a == 2'b10) begin
            m_tx  = d;
            m_txe = 1'b0;
        end
    endtask

    task automatic cpu_read_chk(input logic [1:0] a, input string tag);
        logic [7:0] got, exp;
        @(negedge pro_clk);
        CS = 1'b1; RD = 1'b1; addr = a;
        #2 got = data_bus;
        @(negedge pro_clk);
        CS = 1'b0; RD = 1'b0;
        exp = 8'h00;
        case (a)
            2'b00: exp = m_ctrl;
            2'b01: begin exp = m_status(); m_ovr = 1'b0; end
            2'b10: exp = m_tx;
            default: begin exp = m_rxd; m_rxf = 1'b0; end
        endcase
        chk(tag, got, exp);
    endtask

    task automatic chk_irq(input string tag);
        chk(tag, {7'b0, irq}, {7'b0, m_rxf & m_ctrl[0]});
    endtask

    task automatic chk_miso_idle(input string tag);
        chk(tag, {7'b0, miso}, 8'h01);
    endtask

    task automatic set_idle_sclk();
        sclk = m_ctrl[3];
        repeat (4) @(negedge pro_clk);
    endtask

    task automatic ss_begin();
        @(negedge pro_clk);
        ss_n   = 1'b0;
        m_busy = 1'b1;
        m_load = m_tx;
        m_txe  = 1'b1;
        repeat (8) @(negedge pro_clk);
    endtask

    task automatic ss_end();
        ss_n   = 1'b1;
        m_busy = 1'b0;
        repeat (8) @(negedge pro_clk);
    endtask

    // Master side of one byte (or a partial byte of nbits), half-period of 4 pro_clk cycles.
    task automatic xfer_byte(input logic [7:0] tx, input int nbits);
        logic       cpol, cpha;
        logic [7:0] rx;
        cpol = m_ctrl[3];
        cpha = m_ctrl[4];
        rx   = 8'h00;
        if (!cpha) begin
            mosi = tx[7];
            repeat (4) @(negedge pro_clk);
        end
        for (int i = 0; i < nbits; i++) begin
            if (cpha) mosi = tx[7-i];
            else      rx = {rx[6:0], miso};
            sclk = ~cpol;
            repeat (4) @(negedge pro_clk);
            if (cpha) rx = {rx[6:0], miso};
            sclk = cpol;
            if (!cpha && i < 7) mosi = tx[6-i];
            repeat (4) @(negedge pro_clk);
        end
        if (nbits == 8) begin
            chk("master_rx", rx, m_load);
            if (m_rxf) m_ovr = 1'b1;
            m_rxd  = tx;
            m_rxf  = 1'b1;
            m_load = m_tx;
            m_txe  = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        // Reset state, observed while rst_n is held low.
        repeat (3) @(negedge pro_clk);
        chk_miso_idle("rst_miso");
        chk_irq("rst_irq");
        cpu_read_chk(2'b00, "rst_ctrl");
        cpu_read_chk(2'b01, "rst_status");
        cpu_read_chk(2'b10, "rst_tx");
        cpu_read_chk(2'b11, "rst_rx");
        rst_n = 1'b1;
        repeat (4) @(negedge pro_clk);

        // Mode 0 with irq enabled.
        cpu_write(2'b00, 8'h01);
        set_idle_sclk();
        cpu_write(2'b10, 8'hA5);
        cpu_read_chk(2'b01, "m0_status_pre");
        ss_begin();
        xfer_byte(8'h3C, 8);
        cpu_read_chk(2'b01, "m0_status_busy");
        chk_irq("m0_irq");
        ss_end();
        chk_miso_idle("m0_miso_idle");
        cpu_read_chk(2'b11, "m0_rx");
        chk_irq("m0_irq_clr");

        // Mode 3.
        cpu_write(2'b00, 8'h18);
        set_idle_sclk();
        cpu_write(2'b10, 8'h81);
        ss_begin();
        xfer_byte(8'hC3, 8);
        ss_end();
        cpu_read_chk(2'b01, "m3_status");
        cpu_read_chk(2'b11, "m3_rx");

        // Two bytes under one select without an rx read: overrun.
        cpu_write(2'b00, 8'h00);
        set_idle_sclk();
        ss_begin();
        xfer_byte(8'h11, 8);
        xfer_byte(8'h22, 8);
        ss_end();
        cpu_read_chk(2'b01, "ovr_status");
        cpu_read_chk(2'b11, "ovr_rx");
        cpu_read_chk(2'b01, "ovr_status_clr");

        // Aborted partial byte, then a good one.
        ss_begin();
        xfer_byte(8'hFF, 5);
        ss_end();
        cpu_read_chk(2'b01, "abort_status");
        cpu_read_chk(2'b11, "abort_rx");
        ss_begin();
        xfer_byte(8'h5A, 8);
        ss_end();
        cpu_read_chk(2'b11, "after_abort_rx");

        // Reset during a transfer.
        cpu_write(2'b10, 8'h3D);
        ss_begin();
        xfer_byte(8'hE7, 3);
        @(negedge pro_clk);
        rst_n = 1'b0;
        ss_n  = 1'b1;
        m_reset();
        #1 chk_miso_idle("midrst_miso");
        cpu_read_chk(2'b00, "midrst_ctrl");
        cpu_read_chk(2'b01, "midrst_status");
        cpu_read_chk(2'b10, "midrst_tx");
        cpu_read_chk(2'b11, "midrst_rx");
        rst_n = 1'b1;
        repeat (4) @(negedge pro_clk);
        cpu_write(2'b00, 8'h10);
        set_idle_sclk();
        ss_begin();
        xfer_byte(8'h96, 8);
        ss_end();
        cpu_read_chk(2'b01, "m1_status");
        cpu_read_chk(2'b11, "m1_rx");

        // Retransmission of an un-rewritten tx_data.
        cpu_write(2'b00, 8'h00);
        set_idle_sclk();
        cpu_write(2'b10, 8'h7E);
        ss_begin();
        cpu_read_chk(2'b01, "retx_status_load");
        xfer_byte(8'h01, 8);
        cpu_read_chk(2'b01, "retx_status_mid");
        xfer_byte(8'h02, 8);
        ss_end();
        cpu_read_chk(2'b01, "retx_status_end");
        cpu_read_chk(2'b11, "retx_rx");

        // Randomized modes, payloads, byte counts and aborts.
        for (int it = 0; it < 12; it++) begin
            logic [7:0] c;
            int         nb;
            c = 8'($urandom);
            cpu_write(2'b00, c);
            set_idle_sclk();
            if ($urandom_range(0, 1) == 1) cpu_write(2'b10, 8'($urandom));
            ss_begin();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) xfer_byte(8'($urandom), 8);
            if ($urandom_range(0, 3) == 0) xfer_byte(8'($urandom), $urandom_range(1, 7));
            ss_end();
            chk_miso_idle("rnd_miso_idle");
            chk_irq("rnd_irq");
            cpu_read_chk(2'b01, "rnd_status");
            if ($urandom_range(0, 2) != 0) cpu_read_chk(2'b11, "rnd_rx");
            cpu_read_chk(2'b00, "rnd_ctrl");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
